// File: rtl/hls_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hls_run_sequencer
//  Purpose  : Run controller for a Bambu-generated HLS core. For each of a
//             commanded number of runs it holds the core in reset, issues a
//             one-cycle start pulse, times the run until done_port and emits
//             one result record over a valid/ready port.
//  Ports    : clock, reset           - clock / synchronous active-high reset
//             cmd_start, cmd_runs    - sequence command (sampled in IDLE)
//             busy                   - sequence in progress
//             core_rst, start_port   - core control
//             done_port              - core completion
//             res_valid/res_ready    - result record handshake
//             res_index, res_cycles,
//             res_timeout            - result record fields
//             total_cycles           - saturating sum of res_cycles
//             all_done               - end-of-sequence pulse
//  Options  : HLS_RUN_SEQ_TIMEOUT_EN - enables the per-run watchdog
//             (MAX_CYCLES); when undefined res_timeout is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module hls_run_sequencer #(
    parameter int CNT_W           = 32,
    parameter int RUN_W           = 16,
    parameter int CORE_RST_CYCLES = 2,
    parameter int MAX_CYCLES      = 200000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic [RUN_W-1:0] cmd_runs,
    output logic             busy,
    output logic             core_rst,
    output logic             start_port,
    input  logic             done_port,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RUN_W-1:0] res_index,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_timeout,
    output logic [CNT_W-1:0] total_cycles,
    output logic             all_done
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CORE_RST = 3'd1;
    localparam logic [2:0] c_ST_START    = 3'd2;
    localparam logic [2:0] c_ST_WAIT     = 3'd3;
    localparam logic [2:0] c_ST_REPORT   = 3'd4;

    localparam int                     c_RST_CNT_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;
    localparam logic [c_RST_CNT_W-1:0] c_RST_LAST  = c_RST_CNT_W'(CORE_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_CNT_ALL1  = '1;

    generate
        if (CORE_RST_CYCLES < 1 || MAX_CYCLES < 1) begin : g_bad_params
            $error("hls_run_sequencer: CORE_RST_CYCLES and MAX_CYCLES must be >= 1");
        end
    endgenerate

    logic [2:0]             r_state;
    logic [c_RST_CNT_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0]       r_cnt;
    logic [RUN_W-1:0]       r_runs;
    logic                   r_busy;
    logic                   r_core_rst;
    logic                   r_start_port;
    logic                   r_res_valid;
    logic                   r_res_timeout;
    logic                   r_all_done;
    logic [RUN_W-1:0]       r_res_index;
    logic [CNT_W-1:0]       r_res_cycles;
    logic [CNT_W-1:0]       r_total_cycles;

    logic [2:0]             w_state;
    logic [c_RST_CNT_W-1:0] w_rst_cnt;
    logic [CNT_W-1:0]       w_cnt;
    logic [RUN_W-1:0]       w_runs;
    logic                   w_res_timeout;
    logic                   w_all_done;
    logic [RUN_W-1:0]       w_res_index;
    logic [CNT_W-1:0]       w_res_cycles;
    logic [CNT_W-1:0]       w_total_cycles;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [CNT_W:0]         w_sum;
    logic [CNT_W-1:0]       w_sum_sat;
    logic                   w_last_run;

    // Latency counter value including the current WAIT cycle, saturating.
    assign w_cnt_inc  = (r_cnt == c_CNT_ALL1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_sum      = {1'b0, r_total_cycles} + {1'b0, r_res_cycles};
    assign w_sum_sat  = w_sum[CNT_W] ? c_CNT_ALL1 : w_sum[CNT_W-1:0];
    assign w_last_run = (r_res_index == r_runs - RUN_W'(1));

    always_comb begin
        w_state        = r_state;
        w_rst_cnt      = r_rst_cnt;
        w_cnt          = r_cnt;
        w_runs         = r_runs;
        w_res_timeout  = r_res_timeout;
        w_all_done     = 1'b0;
        w_res_index    = r_res_index;
        w_res_cycles   = r_res_cycles;
        w_total_cycles = r_total_cycles;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_start) begin
                    if (cmd_runs != '0) begin
                        w_state        = c_ST_CORE_RST;
                        w_runs         = cmd_runs;
                        w_res_index    = '0;
                        w_total_cycles = '0;
                        w_rst_cnt      = '0;
                        w_res_timeout  = 1'b0;
                    end else begin
                        w_all_done = 1'b1;
                    end
                end
            end
            c_ST_CORE_RST: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state = c_ST_START;
                end else begin
                    w_rst_cnt = r_rst_cnt + c_RST_CNT_W'(1);
                end
            end
            c_ST_START: begin
                w_cnt = CNT_W'(1);
                if (done_port) begin
                    w_res_cycles = CNT_W'(1);
                    w_state      = c_ST_REPORT;
                end else begin
                    w_state = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                w_cnt = w_cnt_inc;
                if (done_port) begin
                    w_res_cycles = w_cnt_inc;
                    w_state      = c_ST_REPORT;
                end
`ifdef HLS_RUN_SEQ_TIMEOUT_EN
                else if (w_cnt_inc >= CNT_W'(MAX_CYCLES)) begin
                    w_res_cycles  = CNT_W'(MAX_CYCLES);
                    w_res_timeout = 1'b1;
                    w_state       = c_ST_REPORT;
                end
`endif
            end
            c_ST_REPORT: begin
                if (res_ready) begin
                    w_total_cycles = w_sum_sat;
                    w_res_timeout  = 1'b0;
                    // A timed-out core is left in reset and the rest of the
                    // sequence is abandoned.
                    if (w_last_run || r_res_timeout) begin
                        w_state    = c_ST_IDLE;
                        w_all_done = 1'b1;
                    end else begin
                        w_res_index = r_res_index + RUN_W'(1);
                        w_rst_cnt   = '0;
                        w_state     = c_ST_CORE_RST;
                    end
                end
            end
            default: begin
                w_state = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe without any input-to-output path.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_rst_cnt      <= '0;
            r_cnt          <= '0;
            r_runs         <= '0;
            r_busy         <= 1'b0;
            r_core_rst     <= 1'b0;
            r_start_port   <= 1'b0;
            r_res_valid    <= 1'b0;
            r_res_timeout  <= 1'b0;
            r_all_done     <= 1'b0;
            r_res_index    <= '0;
            r_res_cycles   <= '0;
            r_total_cycles <= '0;
        end else begin
            r_state        <= w_state;
            r_rst_cnt      <= w_rst_cnt;
            r_cnt          <= w_cnt;
            r_runs         <= w_runs;
            r_busy         <= (w_state != c_ST_IDLE);
            r_core_rst     <= (w_state == c_ST_CORE_RST) || ((w_state == c_ST_REPORT) && w_res_timeout);
            r_start_port   <= (w_state == c_ST_START);
            r_res_valid    <= (w_state == c_ST_REPORT);
            r_res_timeout  <= w_res_timeout;
            r_all_done     <= w_all_done;
            r_res_index    <= w_res_index;
            r_res_cycles   <= w_res_cycles;
            r_total_cycles <= w_total_cycles;
        end
    end

    assign busy         = r_busy;
    assign core_rst     = r_core_rst;
    assign start_port   = r_start_port;
    assign res_valid    = r_res_valid;
    assign all_done     = r_all_done;
    assign res_index    = r_res_index;
    assign res_cycles   = r_res_cycles;
    assign total_cycles = r_total_cycles;
`ifdef HLS_RUN_SEQ_TIMEOUT_EN
    assign res_timeout  = r_res_timeout;
`else
    assign res_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hls_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hls_run_sequencer
//  Purpose  : Self-checking bench for hls_run_sequencer. A cycle-timestamp
//             model predicts every output each cycle from the command,
//             reset, ready and core-latency inputs; directed sequences are
//             followed by randomized ones.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hls_run_sequencer;

    localparam int CNT_W = 32;
    localparam int RUN_W = 16;
    localparam int CRC   = 2;
`ifdef HLS_RUN_SEQ_TIMEOUT_EN
    localparam int MAXC  = 50;
`else
    localparam int MAXC  = 200000000;
`endif
    localparam int INF   = 32'h7fffffff;

    logic             clock     = 1'b0;
    logic             reset     = 1'b1;
    logic             cmd_start = 1'b0;
    logic [RUN_W-1:0] cmd_runs  = '0;
    logic             done_port = 1'b0;
    logic             res_ready = 1'b0;
    logic             busy, core_rst, start_port, res_valid, res_timeout, all_done;
    logic [RUN_W-1:0] res_index;
    logic [CNT_W-1:0] res_cycles, total_cycles;

    hls_run_sequencer #(
        .CNT_W(CNT_W), .RUN_W(RUN_W), .CORE_RST_CYCLES(CRC), .MAX_CYCLES(MAXC)
    ) dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_runs(cmd_runs),
        .busy(busy), .core_rst(core_rst), .start_port(start_port), .done_port(done_port),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .res_cycles(res_cycles), .res_timeout(res_timeout), .total_cycles(total_cycles),
        .all_done(all_done)
    );

    always #5 clock = ~clock;

    // Counters and observation variables
    int       n_cmp = 0, n_fail = 0;
    int       n_rec = 0, n_alldone = 0;
    longint   last_cycles = 0;
    int       last_to = 0;

    // Timestamp model of the sequencer
    int       t = 0;
    bit       m_active = 0, m_to = 0, m_post_reset = 0;
    int       m_runs = 0, m_run = 0, m_L = 0;
    int       m_rst_lo = INF, m_rst_hi = INF, m_start_cyc = INF;
    int       m_valid_cyc = INF, m_done_cyc = INF, m_alldone_cyc = -1;
    longint   m_total = 0;
    int       lat_q[$];
    bit       e_busy, e_core_rst, e_start, e_valid, e_all_done;
    longint   e_cyc;

    // Stimulus controls
    bit       ready_random = 0, noise = 0;
    int       stall_run = -1, stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
        end
    endtask

    always @(negedge clock) begin
        t++;
        e_busy     = m_active;
        e_valid    = m_active && (t >= m_valid_cyc);
        e_core_rst = m_active && ((t >= m_rst_lo && t <= m_rst_hi) || (m_to && e_valid));
        e_start    = m_active && (t == m_start_cyc);
        e_all_done = (t == m_alldone_cyc);
        e_cyc      = m_to ? longint'(MAXC) : longint'(m_L);

        check("busy", {63'd0, busy}, {63'd0, e_busy});
        check("core_rst", {63'd0, core_rst}, {63'd0, e_core_rst});
        check("start_port", {63'd0, start_port}, {63'd0, e_start});
        check("res_valid", {63'd0, res_valid}, {63'd0, e_valid});
        check("all_done", {63'd0, all_done}, {63'd0, e_all_done});
        check("res_timeout", {63'd0, res_timeout}, {63'd0, e_valid && m_to});
        check("total_cycles", 64'(total_cycles), 64'(m_total));
        if (e_valid) begin
            check("res_index", 64'(res_index), 64'(m_run));
            check("res_cycles", 64'(res_cycles), 64'(e_cyc));
        end
        if (m_post_reset) begin
            check("rst_res_index", 64'(res_index), 64'd0);
            check("rst_res_cycles", 64'(res_cycles), 64'd0);
        end

        // Core model: pick this run's latency on the start cycle
        if (e_start) begin
            m_L = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(1, 12));
            m_to        = (m_L == 0);
            m_done_cyc  = m_to ? INF : t + m_L - 1;
            m_valid_cyc = m_to ? t + MAXC : t + m_L;
        end
        if (m_active && t == m_done_cyc)
            done_port = 1'b1;
        else if (!e_busy || e_core_rst)
            done_port = ($urandom_range(0, 3) == 0);
        else
            done_port = 1'b0;

        if (e_valid && m_run == stall_run && stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
        end else begin
            res_ready = ready_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        end

        n_alldone += int'(all_done);
        if (res_valid && res_ready) begin
            n_rec++;
            last_cycles = longint'(res_cycles);
            last_to     = int'(res_timeout);
        end

        if (reset) begin
            m_active      = 0;
            m_to          = 0;
            m_total       = 0;
            m_post_reset  = 1;
            m_alldone_cyc = -1;
        end else begin
            m_post_reset = 0;
            if (e_valid && res_ready) begin
                m_total += e_cyc;
                if (m_run == m_runs - 1 || m_to) begin
                    m_active      = 0;
                    m_alldone_cyc = t + 1;
                end else begin
                    m_run++;
                    m_rst_lo    = t + 1;
                    m_rst_hi    = t + CRC;
                    m_start_cyc = t + CRC + 1;
                    m_valid_cyc = INF;
                    m_done_cyc  = INF;
                    m_to        = 0;
                end
            end
            if (!e_busy && cmd_start) begin
                if (cmd_runs != 0) begin
                    m_active    = 1;
                    m_runs      = int'(cmd_runs);
                    m_run       = 0;
                    m_total     = 0;
                    m_to        = 0;
                    m_rst_lo    = t + 1;
                    m_rst_hi    = t + CRC;
                    m_start_cyc = t + CRC + 1;
                    m_valid_cyc = INF;
                    m_done_cyc  = INF;
                end else begin
                    m_alldone_cyc = t + 1;
                end
            end
        end
    end

    task automatic run_seq(input int n);
        @(posedge clock); #2;
        cmd_start = 1'b1;
        cmd_runs  = RUN_W'(n);
        @(posedge clock); #2;
        cmd_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (m_active && k < budget) begin
            @(posedge clock); #2;
            if (noise && $urandom_range(0, 19) == 0) begin
                cmd_start = 1'b1;
                cmd_runs  = RUN_W'($urandom_range(0, 3));
            end else begin
                cmd_start = 1'b0;
            end
            k++;
        end
        cmd_start = 1'b0;
        if (m_active) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: busy after %0d cycles, required idle", budget);
        end
        repeat (3) @(posedge clock);
        #2;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;

        // One run, done 10 cycles after start -> 11 cycles
        n_rec = 0; n_alldone = 0;
        lat_q.push_back(11);
        run_seq(1);
        wait_idle(200);
        check("t1_records", 64'(n_rec), 64'd1);
        check("t1_cycles", 64'(last_cycles), 64'd11);
        check("t1_total", 64'(total_cycles), 64'd11);
        check("t1_all_done", 64'(n_alldone), 64'd1);

        // Three runs 5/7/9 with record 1 stalled for four cycles
        n_rec = 0; n_alldone = 0;
        lat_q.push_back(5); lat_q.push_back(7); lat_q.push_back(9);
        stall_run = 1; stall_left = 4;
        run_seq(3);
        wait_idle(300);
        stall_run = -1;
        check("t2_records", 64'(n_rec), 64'd3);
        check("t2_total", 64'(total_cycles), 64'd21);
        check("t2_stall_used", 64'(stall_left), 64'd0);

        // done_port in the start cycle
        n_rec = 0;
        lat_q.push_back(1);
        run_seq(1);
        wait_idle(100);
        check("t3_cycles", 64'(last_cycles), 64'd1);

        // Zero runs: all_done only
        n_rec = 0; n_alldone = 0;
        run_seq(0);
        wait_idle(20);
        check("t4_all_done", 64'(n_alldone), 64'd1);
        check("t4_records", 64'(n_rec), 64'd0);

`ifdef HLS_RUN_SEQ_TIMEOUT_EN
        // Core never completes: one timed-out record, sequence abandoned
        n_rec = 0; n_alldone = 0;
        lat_q.push_back(0);
        run_seq(4);
        wait_idle(500);
        check("to_records", 64'(n_rec), 64'd1);
        check("to_cycles", 64'(last_cycles), 64'd50);
        check("to_flag", 64'(last_to), 64'd1);
        check("to_all_done", 64'(n_alldone), 64'd1);
`endif

        // Reset while run 1 of 3 is waiting, then restart
        n_rec = 0; n_alldone = 0;
        lat_q.push_back(20); lat_q.push_back(20); lat_q.push_back(20);
        run_seq(3);
        k = 0;
        while (!(m_active && m_run == 1 && m_start_cyc != INF && t > m_start_cyc + 2) && k < 500) begin
            @(posedge clock); #2;
            k++;
        end
        check("t5_reached_wait", 64'(k < 500), 64'd1);
        reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        lat_q.delete();
        repeat (2) @(posedge clock);
        #2;
        check("t5_records_before", 64'(n_rec), 64'd1);
        check("t5_no_all_done", 64'(n_alldone), 64'd0);
        n_rec = 0;
        run_seq(2);
        wait_idle(300);
        check("t5_records_after", 64'(n_rec), 64'd2);
        check("t5_all_done", 64'(n_alldone), 64'd1);

        // Randomized sequences with random back-pressure and stray commands
        ready_random = 1;
        noise        = 1;
        for (int i = 0; i < 25; i++) begin
            run_seq(int'($urandom_range(0, 4)));
            wait_idle(3000);
        end
        noise = 0;
        repeat (5) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
